// File: rtl/p_hardisc.sv
// Shared Hardisc definitions used by the CLINT.
// Contents:
//   CLINT_OFF_*       word offsets of the CLINT register map
//   clint_resp_t      AHB response FSM states
//   clint_off_mapped  true when an offset selects a mapped register
package p_hardisc;

  localparam int unsigned CLINT_OFF_MSIP      = 32'h00;
  localparam int unsigned CLINT_OFF_MTIMECMPL = 32'h08;
  localparam int unsigned CLINT_OFF_MTIMECMPH = 32'h0C;
  localparam int unsigned CLINT_OFF_MTIMEL    = 32'h10;
  localparam int unsigned CLINT_OFF_MTIMEH    = 32'h14;
  localparam int unsigned CLINT_OFF_PRESC     = 32'h18;

  typedef enum logic [1:0] {
    OKAY,
    ERR1,
    ERR2
  } clint_resp_t;

  function automatic logic clint_off_mapped(input logic [31:0] off);
    logic hit;
    hit = 1'b0;
    case (off)
      CLINT_OFF_MSIP,
      CLINT_OFF_MTIMECMPL,
      CLINT_OFF_MTIMECMPH,
      CLINT_OFF_MTIMEL,
      CLINT_OFF_MTIMEH,
      CLINT_OFF_PRESC:     hit = 1'b1;
      default:             hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/clint_ahb_port.sv
// AHB-Lite slave front end of the CLINT: address-phase capture, legality check and
// the OKAY/ERR1/ERR2 response FSM.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   hsel, haddr, htrans, hsize,     AHB address-phase inputs (haddr already trimmed to OFF_W)
//   hwrite, hready
//   hwdata                          AHB write data (data phase)
//   hreadyout, hresp                AHB response
//   wr_en, rd_en                    legal write / read in the current data phase
//   off                             offset of the current data phase
//   wdata                           write data for the register file
module clint_ahb_port
  import p_hardisc::*;
#(
  parameter int unsigned OFF_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hsel,
  input  logic [OFF_W-1:0] haddr,
  input  logic [1:0]       htrans,
  input  logic [2:0]       hsize,
  input  logic             hwrite,
  input  logic             hready,
  input  logic [31:0]      hwdata,
  output logic             hreadyout,
  output logic             hresp,
  output logic             wr_en,
  output logic             rd_en,
  output logic [OFF_W-1:0] off,
  output logic [31:0]      wdata
);

  logic             accept;
  logic             legal;
  logic             dp_valid_q;
  logic             dp_write_q;
  logic             dp_legal_q;
  logic [OFF_W-1:0] dp_off_q;
  clint_resp_t      state_q, state_d;

  assign accept = hsel & htrans[1] & hready;
  assign legal  = clint_off_mapped(32'(haddr)) & (hsize == 3'b010) & (haddr[1:0] == 2'b00);

  // Data-phase capture only advances on hready so a stalled data phase keeps its context.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid_q <= 1'b0;
      dp_write_q <= 1'b0;
      dp_legal_q <= 1'b0;
      dp_off_q   <= '0;
    end else if (hready) begin
      dp_valid_q <= accept;
      dp_write_q <= hwrite;
      dp_legal_q <= legal;
      dp_off_q   <= haddr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OKAY;
    end else begin
      state_q <= state_d;
    end
  end

  // The error decision is taken at acceptance so ERR1 coincides with the illegal data phase.
  always_comb begin
    state_d   = state_q;
    hreadyout = 1'b1;
    hresp     = 1'b0;
    unique case (state_q)
      OKAY: begin
        if (accept && !legal) state_d = ERR1;
      end
      ERR1: begin
        hreadyout = 1'b0;
        hresp     = 1'b1;
        state_d   = ERR2;
      end
      ERR2: begin
        hresp   = 1'b1;
        state_d = (accept && !legal) ? ERR1 : OKAY;
      end
      default: state_d = OKAY;
    endcase
  end

  assign wr_en = dp_valid_q & dp_write_q & dp_legal_q & hready;
  assign rd_en = dp_valid_q & ~dp_write_q & dp_legal_q;
  assign off   = dp_off_q;
  assign wdata = hwdata;

endmodule

// File: rtl/hrd_clint.sv
// Core-local interrupt source: 64-bit mtime/mtimecmp timer with prescaler and a software
// interrupt register, behind a zero-wait AHB-Lite slave.
// Ports:
//   s_clk_i, s_resetn_i      clock, asynchronous active-low reset
//   s_h*_i                   AHB-Lite slave inputs
//   s_hrdata_o               read data (data phase), 0 when no legal read
//   s_hreadyout_o, s_hresp_o AHB response
//   s_int_mtip_o             timer interrupt pending (registered mtime >= mtimecmp)
//   s_int_msip_o             software interrupt pending (MSIP[0])
//   s_mtime_o                current mtime
module hrd_clint
  import p_hardisc::*;
#(
  parameter int unsigned OFF_W   = 8,
  parameter int unsigned PRESC_W = 16
) (
  input  logic        s_clk_i,
  input  logic        s_resetn_i,
  input  logic        s_hsel_i,
  input  logic [31:0] s_haddr_i,
  input  logic [1:0]  s_htrans_i,
  input  logic [2:0]  s_hsize_i,
  input  logic        s_hwrite_i,
  input  logic [31:0] s_hwdata_i,
  input  logic        s_hready_i,
  output logic [31:0] s_hrdata_o,
  output logic        s_hreadyout_o,
  output logic        s_hresp_o,
  output logic        s_int_mtip_o,
  output logic        s_int_msip_o,
  output logic [63:0] s_mtime_o
);

  logic               wr_en;
  logic               rd_en;
  logic [OFF_W-1:0]   off;
  logic [31:0]        wdata;
  logic               unused_haddr;

  logic               msip_q, msip_d;
  logic [63:0]        mtimecmp_q, mtimecmp_d;
  logic [63:0]        mtime_q, mtime_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic               mtip_q;
  logic               tick;

  // Upper address bits are qualified by hsel in the interconnect.
  assign unused_haddr = ^s_haddr_i[31:OFF_W];

  clint_ahb_port #(
    .OFF_W(OFF_W)
  ) u_port (
    .clk       (s_clk_i),
    .rst_n     (s_resetn_i),
    .hsel      (s_hsel_i),
    .haddr     (s_haddr_i[OFF_W-1:0]),
    .htrans    (s_htrans_i),
    .hsize     (s_hsize_i),
    .hwrite    (s_hwrite_i),
    .hready    (s_hready_i),
    .hwdata    (s_hwdata_i),
    .hreadyout (s_hreadyout_o),
    .hresp     (s_hresp_o),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .off       (off),
    .wdata     (wdata)
  );

  always_comb begin
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    presc_d    = presc_q;
    mtime_d    = mtime_q;
    tick       = (cnt_q == presc_q);
    cnt_d      = tick ? '0 : cnt_q + PRESC_W'(1);
    if (tick) mtime_d = mtime_q + 64'd1;
    // A write to either mtime half replaces the increment for that cycle.
    if (wr_en) begin
      case (off)
        OFF_W'(CLINT_OFF_MSIP):      msip_d = wdata[0];
        OFF_W'(CLINT_OFF_MTIMECMPL): mtimecmp_d = {mtimecmp_q[63:32], wdata};
        OFF_W'(CLINT_OFF_MTIMECMPH): mtimecmp_d = {wdata, mtimecmp_q[31:0]};
        OFF_W'(CLINT_OFF_MTIMEL):    mtime_d = {mtime_q[63:32], wdata};
        OFF_W'(CLINT_OFF_MTIMEH):    mtime_d = {wdata, mtime_q[31:0]};
        OFF_W'(CLINT_OFF_PRESC): begin
          presc_d = wdata[PRESC_W-1:0];
          cnt_d   = '0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge s_clk_i or negedge s_resetn_i) begin
    if (!s_resetn_i) begin
      msip_q     <= 1'b0;
      mtimecmp_q <= '1;
      mtime_q    <= '0;
      presc_q    <= '0;
      cnt_q      <= '0;
      mtip_q     <= 1'b0;
    end else begin
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
      presc_q    <= presc_d;
      cnt_q      <= cnt_d;
      mtip_q     <= (mtime_q >= mtimecmp_q);
    end
  end

  always_comb begin
    s_hrdata_o = '0;
    if (rd_en) begin
      case (off)
        OFF_W'(CLINT_OFF_MSIP):      s_hrdata_o = {31'b0, msip_q};
        OFF_W'(CLINT_OFF_MTIMECMPL): s_hrdata_o = mtimecmp_q[31:0];
        OFF_W'(CLINT_OFF_MTIMECMPH): s_hrdata_o = mtimecmp_q[63:32];
        OFF_W'(CLINT_OFF_MTIMEL):    s_hrdata_o = mtime_q[31:0];
        OFF_W'(CLINT_OFF_MTIMEH):    s_hrdata_o = mtime_q[63:32];
        OFF_W'(CLINT_OFF_PRESC):     s_hrdata_o = 32'(presc_q);
        default:                     s_hrdata_o = '0;
      endcase
    end
  end

  assign s_int_mtip_o = mtip_q;
  assign s_int_msip_o = msip_q;
  assign s_mtime_o    = mtime_q;

endmodule

// File: tb/tb_hrd_clint.sv
// Self-checking bench for hrd_clint: directed scenarios plus random AHB traffic, all
// compared every cycle against a behavioural model of the register map and timer.
module tb_hrd_clint;

  logic        clk = 1'b0;
  logic        rstn;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic        hwrite;
  logic [31:0] hwdata;
  logic        hready;
  logic [31:0] hrdata;
  logic        hreadyout, hresp, mtip, msip;
  logic [63:0] mtime;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model state.
  logic [63:0] m_mtime, m_cmp;
  int unsigned m_presc, m_cnt;
  bit          m_msip, m_mtip;
  int          m_resp;  // 0 okay, 1 first error cycle, 2 second error cycle
  bit          d_valid, d_write;
  logic [7:0]  d_off;

  logic [31:0] addr_tab [10] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10,
                                 32'h14, 32'h18, 32'h0A, 32'h1C, 32'h20};

  assign hready = hreadyout;
  always #5 clk = ~clk;

  hrd_clint #(
    .OFF_W  (8),
    .PRESC_W(16)
  ) dut (
    .s_clk_i      (clk),
    .s_resetn_i   (rstn),
    .s_hsel_i     (hsel),
    .s_haddr_i    (haddr),
    .s_htrans_i   (htrans),
    .s_hsize_i    (hsize),
    .s_hwrite_i   (hwrite),
    .s_hwdata_i   (hwdata),
    .s_hready_i   (hready),
    .s_hrdata_o   (hrdata),
    .s_hreadyout_o(hreadyout),
    .s_hresp_o    (hresp),
    .s_int_mtip_o (mtip),
    .s_int_msip_o (msip),
    .s_mtime_o    (mtime)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_legal(input logic [31:0] a, input logic [2:0] sz);
    logic [7:0] o;
    o = a[7:0];
    return (o == 8'h00 || o == 8'h08 || o == 8'h0C || o == 8'h10 || o == 8'h14 ||
            o == 8'h18) && sz == 3'b010 && a[1:0] == 2'b00;
  endfunction

  function automatic logic [31:0] m_read(input logic [7:0] o);
    case (o)
      8'h00:   return {31'b0, m_msip};
      8'h08:   return m_cmp[31:0];
      8'h0C:   return m_cmp[63:32];
      8'h10:   return m_mtime[31:0];
      8'h14:   return m_mtime[63:32];
      8'h18:   return m_presc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mtime = 64'h0;
    m_cmp   = {64{1'b1}};
    m_presc = 0;
    m_cnt   = 0;
    m_msip  = 0;
    m_mtip  = 0;
    m_resp  = 0;
    d_valid = 0;
    d_write = 0;
    d_off   = 8'h0;
  endtask

  // Advance the model across one rising edge using the bus values held during that cycle.
  task automatic model_edge();
    bit          acc, lg, tick, nmtip;
    logic [63:0] old_mt;
    logic [31:0] wd;
    wd     = hwdata;
    acc    = hsel && htrans[1] && (m_resp != 1);
    lg     = is_legal(haddr, hsize);
    nmtip  = (m_mtime >= m_cmp);
    old_mt = m_mtime;
    tick   = (m_cnt == m_presc);
    m_cnt  = tick ? 0 : m_cnt + 1;
    if (tick) m_mtime = m_mtime + 64'd1;
    if (d_valid && d_write) begin
      case (d_off)
        8'h00: m_msip = wd[0];
        8'h08: m_cmp[31:0] = wd;
        8'h0C: m_cmp[63:32] = wd;
        8'h10: m_mtime = {old_mt[63:32], wd};
        8'h14: m_mtime = {wd, old_mt[31:0]};
        8'h18: begin
          m_presc = wd[15:0];
          m_cnt   = 0;
        end
        default: ;
      endcase
    end
    m_mtip = nmtip;
    if (m_resp != 1) begin
      d_valid = acc && lg;
      d_write = hwrite;
      d_off   = haddr[7:0];
    end
    m_resp = (m_resp == 1) ? 2 : ((acc && !lg) ? 1 : 0);
  endtask

  task automatic check_outputs();
    chk("hreadyout", hreadyout, (m_resp != 1));
    chk("hresp", hresp, (m_resp != 0));
    chk("hrdata", hrdata, (d_valid && !d_write) ? m_read(d_off) : 32'h0);
    chk("mtip", mtip, m_mtip);
    chk("msip", msip, m_msip);
    chk("mtime", mtime, m_mtime);
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Present one transfer, wait for acceptance, then drive its write data; returns in the
  // data phase.
  task automatic xfer(input logic [31:0] a, input bit wr, input logic [2:0] sz,
                      input logic [31:0] wd);
    bit done;
    hsel   = 1'b1;
    haddr  = a;
    htrans = 2'b10;
    hwrite = wr;
    hsize  = sz;
    done   = 0;
    for (int k = 0; k < 4 && !done; k++) begin
      done = (m_resp != 1);
      cyc();
    end
    chk("xfer_accept", done, 1'b1);
    hsel   = 1'b0;
    htrans = 2'b00;
    hwdata = wd;
  endtask

  logic [63:0] t0;
  int unsigned pick;
  logic [31:0] ra, rd;
  logic [2:0]  rs;

  initial begin
    rstn   = 1'b0;
    hsel   = 1'b0;
    haddr  = 32'h0;
    htrans = 2'b00;
    hsize  = 3'b010;
    hwrite = 1'b0;
    hwdata = 32'h0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_hreadyout", hreadyout, 1'b1);
    chk("rst_hresp", hresp, 1'b0);
    chk("rst_hrdata", hrdata, 32'h0);
    chk("rst_mtip", mtip, 1'b0);
    chk("rst_msip", msip, 1'b0);
    chk("rst_mtime", mtime, 64'h0);
    rstn = 1'b1;

    // Free-running at PRESC=0.
    cyc();
    chk("mtime_inc1", mtime, 64'd1);
    cyc();
    chk("mtime_inc2", mtime, 64'd2);
    xfer(32'h08, 0, 3'b010, 32'h0);
    chk("cmp_lo_reset", hrdata, 32'hFFFF_FFFF);
    xfer(32'h0C, 0, 3'b010, 32'h0);
    chk("cmp_hi_reset", hrdata, 32'hFFFF_FFFF);
    cyc();

    // PRESC=3: one increment every four cycles.
    xfer(32'h18, 1, 3'b010, 32'd3);
    cyc();
    t0 = m_mtime;
    repeat (40) cyc();
    chk("presc3_span", mtime, t0 + 64'd10);

    // Carry from LO into HI.
    xfer(32'h18, 1, 3'b010, 32'hFFFF);
    xfer(32'h14, 1, 3'b010, 32'h0);
    xfer(32'h10, 1, 3'b010, 32'hFFFF_FFFE);
    xfer(32'h18, 1, 3'b010, 32'h0);
    cyc();
    chk("carry_start", mtime, 64'h0000_0000_FFFF_FFFE);
    cyc();
    cyc();
    chk("carry_done", mtime, 64'h0000_0001_0000_0000);

    // 64-bit wrap.
    xfer(32'h18, 1, 3'b010, 32'hFFFF);
    xfer(32'h14, 1, 3'b010, 32'hFFFF_FFFF);
    xfer(32'h10, 1, 3'b010, 32'hFFFF_FFFF);
    xfer(32'h18, 1, 3'b010, 32'h0);
    cyc();
    chk("wrap_start", mtime, {64{1'b1}});
    cyc();
    chk("wrap_done", mtime, 64'h0);

    // Timer interrupt rise and clear.
    xfer(32'h18, 1, 3'b010, 32'hFFFF);
    xfer(32'h0C, 1, 3'b010, 32'h0);
    xfer(32'h08, 1, 3'b010, 32'h20);
    xfer(32'h14, 1, 3'b010, 32'h0);
    xfer(32'h10, 1, 3'b010, 32'h1C);
    xfer(32'h18, 1, 3'b010, 32'h0);
    cyc();
    chk("mtip_setup_mtime", mtime, 64'h1C);
    chk("mtip_setup", mtip, 1'b0);
    repeat (4) cyc();
    chk("mtip_at_cmp_mtime", mtime, 64'h20);
    chk("mtip_lag", mtip, 1'b0);
    cyc();
    chk("mtip_rise", mtip, 1'b1);
    xfer(32'h08, 1, 3'b010, 32'h100);
    cyc();
    chk("mtip_hold", mtip, 1'b1);
    cyc();
    chk("mtip_clear", mtip, 1'b0);

    // Software interrupt.
    xfer(32'h00, 1, 3'b010, 32'h1);
    chk("msip_dp", msip, 1'b0);
    cyc();
    chk("msip_set", msip, 1'b1);
    xfer(32'h00, 0, 3'b010, 32'h0);
    chk("msip_read", hrdata, 32'h1);
    xfer(32'h00, 1, 3'b010, 32'h0);
    cyc();
    chk("msip_clr", msip, 1'b0);

    // Illegal accesses.
    xfer(32'h04, 0, 3'b010, 32'h0);
    chk("ill_rd_err1_rdy", hreadyout, 1'b0);
    chk("ill_rd_err1_resp", hresp, 1'b1);
    chk("ill_rd_data", hrdata, 32'h0);
    cyc();
    chk("ill_rd_err2_rdy", hreadyout, 1'b1);
    chk("ill_rd_err2_resp", hresp, 1'b1);
    xfer(32'h00, 0, 3'b010, 32'h0);
    chk("b2b_ok_rdy", hreadyout, 1'b1);
    chk("b2b_ok_resp", hresp, 1'b0);
    xfer(32'h00, 1, 3'b000, 32'h1);
    chk("ill_byte_err1", {hreadyout, hresp}, 2'b01);
    cyc();
    chk("ill_byte_err2", {hreadyout, hresp}, 2'b11);
    cyc();
    cyc();
    chk("ill_byte_msip", msip, 1'b0);
    xfer(32'h0A, 1, 3'b010, 32'hDEAD);
    chk("ill_0a_err1", {hreadyout, hresp}, 2'b01);
    cyc();
    chk("ill_0a_err2", {hreadyout, hresp}, 2'b11);
    xfer(32'h08, 0, 3'b010, 32'h0);
    chk("ill_0a_cmp_kept", hrdata, 32'h100);
    chk("ill_0a_b2b_ok", {hreadyout, hresp}, 2'b10);
    cyc();

    // Random traffic with junk in the undecoded upper address bits.
    for (int i = 0; i < 300; i++) begin
      pick = $urandom_range(0, 9);
      ra   = ($urandom() & 32'hFFFF_FF00) | addr_tab[pick];
      rs   = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 1)) : 3'b010;
      rd   = (addr_tab[pick] == 32'h18) ? $urandom_range(0, 3) : $urandom();
      xfer(ra, $urandom_range(0, 1) == 1, rs, rd);
      if ($urandom_range(0, 3) == 0) cyc();
    end
    cyc();
    cyc();

    // Reset in the middle of an error response.
    xfer(32'h04, 0, 3'b010, 32'h0);
    rstn = 1'b0;
    #1;
    model_reset();
    chk("midrst_rdy", hreadyout, 1'b1);
    chk("midrst_resp", hresp, 1'b0);
    chk("midrst_mtime", mtime, 64'h0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    cyc();
    chk("midrst_run", mtime, 64'd1);
    xfer(32'h10, 0, 3'b010, 32'h0);
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
